// File: rtl/conv2d_tiled_pkg.sv
// Shared types and helpers for the tiled 2-D convolution engine: kernel constant,
// accumulator sizing and FSM states. Optional saturation is selected by CONV2_SATURATE_EN.
package conv2_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } conv_state_t;

  // Laplacian for 3x3, box (all ones) for every other kernel size.
  function automatic int kernel_coef(input int ksize, input int i, input int j);
    if (ksize == 3) begin
      if (i == 1 && j == 1) return 4;
      else if (i == 1 || j == 1) return -1;
      else return 0;
    end
    return 1;
  endfunction

  function automatic int acc_width(input int width_bit, input int ksize);
    return 2 * width_bit + $clog2(ksize * ksize);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_tiled_if.sv
// Image/result bus between the image source (master) and the convolution engine (slave).
// The engine's saturation option (CONV2_SATURATE_EN) does not affect this interface.
interface conv2d_tiled_if #(
  parameter int SIZE      = 256,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16
);
  localparam int N = SIZE - SIZEKer + 1;

  logic signed [WIDTH_BIT-1:0] inpMatrixI      [SIZE][SIZE];
  logic                        done;
  logic signed [WIDTH_BIT-1:0] convIxKernelOut [N][N];

  modport master (output inpMatrixI, input done, input convIxKernelOut);
  modport slave  (input inpMatrixI, output done, output convIxKernelOut);

endinterface

// File: rtl/conv2d_tiled_mac_lane.sv
// Combinational SIZEKer x SIZEKer window multiply-accumulate for one output pixel.
// With CONV2_SATURATE_EN defined the result clamps to the signed range; otherwise it wraps.
module conv2_mac_lane
  import conv2_pkg::*;
#(
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 16
) (
  input  logic signed [WIDTH_BIT-1:0] win [SIZEKer][SIZEKer],
  output logic signed [WIDTH_BIT-1:0] result
);
  localparam int ACCW = acc_width(WIDTH_BIT, SIZEKer);
  localparam int PW   = 2 * WIDTH_BIT;

`ifdef CONV2_SATURATE_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WIDTH_BIT+1){1'b0}}, {(WIDTH_BIT-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WIDTH_BIT+1){1'b1}}, {(WIDTH_BIT-1){1'b0}}};
`endif

  logic signed [ACCW-1:0]      acc;
  logic signed [PW-1:0]        prod;
  logic signed [WIDTH_BIT-1:0] coef;

  always_comb begin
    acc  = '0;
    prod = '0;
    coef = '0;
    for (int i = 0; i < SIZEKer; i++) begin
      for (int j = 0; j < SIZEKer; j++) begin
        coef = WIDTH_BIT'(kernel_coef(SIZEKer, i, j));
        // Both operands widened first so the product is the full signed result.
        prod = PW'(win[i][j]) * PW'(coef);
        acc  = acc + ACCW'(prod);
      end
    end
  end

  always_comb begin
`ifdef CONV2_SATURATE_EN
    if (acc > SAT_MAX)      result = SAT_MAX[WIDTH_BIT-1:0];
    else if (acc < SAT_MIN) result = SAT_MIN[WIDTH_BIT-1:0];
    else                    result = acc[WIDTH_BIT-1:0];
`else
    result = acc[WIDTH_BIT-1:0];
`endif
  end

endmodule

// File: rtl/conv2d_tiled.sv
// Self-starting valid-mode 2-D convolution: TOTSUBIMAGEM output pixels per clock in raster
// order, done when the last group is written. CONV2_SATURATE_EN selects clamping lanes.
module conv2d_tiled
  import conv2_pkg::*;
#(
  parameter int SIZE         = 256,
  parameter int SIZEKer      = 3,
  parameter int WIDTH_BIT    = 16,
  parameter int TOTSUBIMAGEM = 16
) (
  input  logic            clock,
  input  logic            nreset,
  conv2d_tiled_if.slave   bus
);
  localparam int N  = SIZE - SIZEKer + 1;
  localparam int G  = (N + TOTSUBIMAGEM - 1) / TOTSUBIMAGEM;
  localparam int RW = idx_width(N);
  localparam int GW = idx_width(G);
  localparam int IW = idx_width(SIZE);

  conv_state_t state_reg, state_next;
  logic [RW-1:0] row_reg, row_next;
  logic [GW-1:0] grp_reg, grp_next;
  logic          done_reg, done_next;
  logic          do_write;

  int                          lane_colraw [TOTSUBIMAGEM];
  logic                        lane_valid  [TOTSUBIMAGEM];
  logic [RW-1:0]               lane_col    [TOTSUBIMAGEM];
  logic signed [WIDTH_BIT-1:0] win_all     [TOTSUBIMAGEM][SIZEKer][SIZEKer];
  logic signed [WIDTH_BIT-1:0] lane_result [TOTSUBIMAGEM];

  // Masked lanes read column 0 so no index ever leaves the image.
  always_comb begin
    for (int k = 0; k < TOTSUBIMAGEM; k++) begin
      lane_colraw[k] = int'(grp_reg) * TOTSUBIMAGEM + k;
      lane_valid[k]  = (lane_colraw[k] < N);
      lane_col[k]    = lane_valid[k] ? RW'(lane_colraw[k]) : '0;
      for (int i = 0; i < SIZEKer; i++) begin
        for (int j = 0; j < SIZEKer; j++) begin
          win_all[k][i][j] = bus.inpMatrixI[IW'(int'(row_reg) + i)][IW'(int'(lane_col[k]) + j)];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < TOTSUBIMAGEM; gi++) begin : g_lane
      conv2_mac_lane #(
        .SIZEKer  (SIZEKer),
        .WIDTH_BIT(WIDTH_BIT)
      ) u_lane (
        .win   (win_all[gi]),
        .result(lane_result[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    grp_next   = grp_reg;
    done_next  = done_reg;
    do_write   = 1'b0;
    case (state_reg)
      RUN: begin
        do_write = 1'b1;
        if (grp_reg == GW'(G - 1)) begin
          grp_next = '0;
          if (row_reg == RW'(N - 1)) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            row_next = row_reg + RW'(1);
          end
        end else begin
          grp_next = grp_reg + GW'(1);
        end
      end
      DONE: begin
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_reg <= RUN;
      row_reg   <= '0;
      grp_reg   <= '0;
      done_reg  <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          bus.convIxKernelOut[RW'(r)][RW'(c)] <= '0;
        end
      end
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      grp_reg   <= grp_next;
      done_reg  <= done_next;
      if (do_write) begin
        for (int k = 0; k < TOTSUBIMAGEM; k++) begin
          if (lane_valid[k]) bus.convIxKernelOut[row_reg][lane_col[k]] <= lane_result[k];
        end
      end
    end
  end

  assign bus.done = done_reg;

endmodule

// File: tb/tb_conv2d_tiled.sv
// Directed bench: small 5x5/3x3/2-lane instance for function checks, default-size
// instance for full-run latency. Expected values are hand-derived constants.
module tb_conv2d_tiled;
  import conv2_pkg::*;

  localparam int SS = 5;
  localparam int SN = 3;
  localparam int BS = 256;
  localparam int BN = 254;

  logic clk;
  logic nreset_s;
  logic nreset_b;
  int   n_cmp;
  int   n_err;

  conv2d_tiled_if #(.SIZE(SS), .SIZEKer(3), .WIDTH_BIT(16)) sbus ();
  conv2d_tiled_if #(.SIZE(BS), .SIZEKer(3), .WIDTH_BIT(16)) bbus ();

  conv2d_tiled #(.SIZE(SS), .SIZEKer(3), .WIDTH_BIT(16), .TOTSUBIMAGEM(2)) u_small (
    .clock (clk),
    .nreset(nreset_s),
    .bus   (sbus)
  );

  conv2d_tiled #(.SIZE(BS), .SIZEKer(3), .WIDTH_BIT(16), .TOTSUBIMAGEM(16)) u_big (
    .clock (clk),
    .nreset(nreset_b),
    .bus   (bbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] exp_imp [SN][SN] = '{'{16'sd0, -16'sd1, 16'sd0},
                                           '{-16'sd1, 16'sd4, -16'sd1},
                                           '{16'sd0, -16'sd1, 16'sd0}};

  task automatic fill_small(input logic signed [15:0] bg, input logic signed [15:0] center);
    for (int r = 0; r < SS; r++)
      for (int c = 0; c < SS; c++)
        sbus.inpMatrixI[r][c] = (r == 2 && c == 2) ? center : bg;
  endtask

  task automatic hold_reset_small();
    @(negedge clk);
    nreset_s = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Releases reset at a falling edge and counts rising edges until done (bounded).
  task automatic run_small(output int edges);
    edges = 0;
    nreset_s = 1'b1;
    while (edges < 50) begin
      @(posedge clk);
      edges++;
      #1;
      if (sbus.done) break;
    end
  endtask

  task automatic test_reset();
    fill_small(16'sd0, 16'sd1);
    @(negedge clk);
    nreset_s = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sbus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b want 0", sbus.done);
    end
    for (int r = 0; r < SN; r++)
      for (int c = 0; c < SN; c++) begin
        n_cmp++;
        if (sbus.convIxKernelOut[r][c] !== 16'sd0) begin
          n_err++;
          $display("FAIL reset_out[%0d][%0d]: got %h want 0000", r, c, sbus.convIxKernelOut[r][c]);
        end
      end
    $display("test_reset: done");
  endtask

  task automatic test_impulse();
    int edges;
    hold_reset_small();
    fill_small(16'sd0, 16'sd1);
    run_small(edges);
    n_cmp++;
    if (edges != 6) begin
      n_err++;
      $display("FAIL impulse_latency: got %0d edges want 6", edges);
    end
    for (int r = 0; r < SN; r++)
      for (int c = 0; c < SN; c++) begin
        n_cmp++;
        if (sbus.convIxKernelOut[r][c] !== exp_imp[r][c]) begin
          n_err++;
          $display("FAIL impulse_out[%0d][%0d]: got %h want %h", r, c, sbus.convIxKernelOut[r][c], exp_imp[r][c]);
        end
      end
    $display("test_impulse: done after %0d edges", edges);
  endtask

  task automatic test_post_done();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (sbus.done !== 1'b1) begin
      n_err++;
      $display("FAIL post_done_flag: got %b want 1", sbus.done);
    end
    for (int r = 0; r < SN; r++)
      for (int c = 0; c < SN; c++) begin
        n_cmp++;
        if (sbus.convIxKernelOut[r][c] !== exp_imp[r][c]) begin
          n_err++;
          $display("FAIL post_done_out[%0d][%0d]: got %h want %h", r, c, sbus.convIxKernelOut[r][c], exp_imp[r][c]);
        end
      end
    $display("test_post_done: done");
  endtask

  task automatic test_constant();
    int edges;
    hold_reset_small();
    fill_small(16'sd5, 16'sd5);
    run_small(edges);
    n_cmp++;
    if (edges != 6) begin
      n_err++;
      $display("FAIL const_latency: got %0d edges want 6", edges);
    end
    for (int r = 0; r < SN; r++)
      for (int c = 0; c < SN; c++) begin
        n_cmp++;
        if (sbus.convIxKernelOut[r][c] !== 16'sd0) begin
          n_err++;
          $display("FAIL const_out[%0d][%0d]: got %h want 0000", r, c, sbus.convIxKernelOut[r][c]);
        end
      end
    $display("test_constant: done");
  endtask

  task automatic test_overflow();
    int edges;
    logic [15:0] exp_c;
`ifdef CONV2_SATURATE_EN
    exp_c = 16'h7FFF;
`else
    exp_c = 16'hFFFC;
`endif
    hold_reset_small();
    fill_small(16'sd0, 16'sh7FFF);
    run_small(edges);
    n_cmp++;
    if (sbus.convIxKernelOut[1][1] !== exp_c) begin
      n_err++;
      $display("FAIL overflow_center: got %h want %h", sbus.convIxKernelOut[1][1], exp_c);
    end
    n_cmp++;
    if (sbus.convIxKernelOut[0][1] !== 16'h8001) begin
      n_err++;
      $display("FAIL overflow_edge: got %h want 8001", sbus.convIxKernelOut[0][1]);
    end
    n_cmp++;
    if (sbus.convIxKernelOut[0][0] !== 16'h0000) begin
      n_err++;
      $display("FAIL overflow_corner: got %h want 0000", sbus.convIxKernelOut[0][0]);
    end
    $display("test_overflow: center %h", sbus.convIxKernelOut[1][1]);
  endtask

  task automatic test_reset_mid();
    int edges;
    hold_reset_small();
    fill_small(16'sd0, 16'sd1);
    nreset_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sbus.convIxKernelOut[1][1] !== 16'sd4 || sbus.done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_progress: got out11=%h done=%b want 0004/0", sbus.convIxKernelOut[1][1], sbus.done);
    end
    nreset_s = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sbus.done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_done: got %b want 0", sbus.done);
    end
    for (int r = 0; r < SN; r++)
      for (int c = 0; c < SN; c++) begin
        n_cmp++;
        if (sbus.convIxKernelOut[r][c] !== 16'sd0) begin
          n_err++;
          $display("FAIL mid_reset_out[%0d][%0d]: got %h want 0000", r, c, sbus.convIxKernelOut[r][c]);
        end
      end
    @(negedge clk);
    run_small(edges);
    n_cmp++;
    if (edges != 6) begin
      n_err++;
      $display("FAIL mid_rerun_latency: got %0d edges want 6", edges);
    end
    for (int r = 0; r < SN; r++)
      for (int c = 0; c < SN; c++) begin
        n_cmp++;
        if (sbus.convIxKernelOut[r][c] !== exp_imp[r][c]) begin
          n_err++;
          $display("FAIL mid_rerun_out[%0d][%0d]: got %h want %h", r, c, sbus.convIxKernelOut[r][c], exp_imp[r][c]);
        end
      end
    $display("test_reset_mid: rerun done after %0d edges", edges);
  endtask

  task automatic test_default();
    int edges;
    int bad;
    @(negedge clk);
    n_cmp++;
    if (bbus.done !== 1'b0) begin
      n_err++;
      $display("FAIL default_reset_done: got %b want 0", bbus.done);
    end
    nreset_b = 1'b1;
    edges = 0;
    while (edges < 5000) begin
      @(posedge clk);
      edges++;
      #1;
      if (bbus.done) break;
    end
    n_cmp++;
    if (edges != 4064) begin
      n_err++;
      $display("FAIL default_latency: got %0d edges want 4064", edges);
    end
    bad = 0;
    for (int r = 0; r < BN; r++)
      for (int c = 0; c < BN; c++) begin
        n_cmp++;
        if (bbus.convIxKernelOut[r][c] !== 16'sd0) begin
          n_err++;
          if (bad < 5) $display("FAIL default_out[%0d][%0d]: got %h want 0000", r, c, bbus.convIxKernelOut[r][c]);
          bad++;
        end
      end
    $display("test_default: done after %0d edges", edges);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    nreset_s = 1'b0;
    nreset_b = 1'b0;
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        bbus.inpMatrixI[r][c] = 16'sd0;
    test_reset();
    test_impulse();
    test_post_done();
    test_constant();
    test_overflow();
    test_reset_mid();
    test_default();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
